// File: rtl/hyperbus_w_serializer.sv
// hyperbus_w_serializer
// ---------------------
// Write-data stage in front of the HyperBus PHY TX channel. It takes one write
// command (start lane + number of 16-bit words) and wide front-end write beats.
// For each word it emits a 16-bit value with its byte strobes and a last flag.
// A burst always holds exactly the commanded number of words, so the PHY's
// burst counter stays in step with the data. Extra input beats are drained.
// Missing input is filled with fully masked pad words.
//
// Handshakes (cmd_*, data_*, tx_*): a transfer happens on a rising clk_i edge
// where valid and ready are both high. Once valid is raised, the sender holds
// valid and its payload stable until the transfer happens. Ready may depend
// combinationally on the other side's signals; valid never depends on ready.
//
// Ports
//   clk_i, rst_ni      clock, synchronous active-low reset
//   cmd_*              write command: start lane (first beat only), word count
//   data_*             front-end write beats: data, byte strobes, last
//   tx_*               16-bit word stream to the PHY, active-high strobes
//   busy_o             high whenever a command is being served
//   error_o            one-cycle pulse on a length/last mismatch
//   dbg_state_o        current FSM state (0 Idle, 1 Run, 2 Drain)
module hyperbus_w_serializer #(
    parameter  int DataWidth = 32,
    parameter  int LenWidth  = 16,
    localparam int NumLanes  = DataWidth / 16,
    localparam int OffWidth  = (NumLanes > 1) ? $clog2(NumLanes) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [OffWidth-1:0]    cmd_offset_i,
    input  logic [LenWidth-1:0]    cmd_len_i,
    input  logic                   data_valid_i,
    output logic                   data_ready_o,
    input  logic [DataWidth-1:0]   data_i,
    input  logic [DataWidth/8-1:0] strb_i,
    input  logic                   data_last_i,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic [15:0]            tx_data_o,
    output logic [1:0]             tx_strb_o,
    output logic                   tx_last_o,
    output logic                   busy_o,
    output logic                   error_o,
    output logic [1:0]             dbg_state_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic                     buf_valid_q, buf_valid_d;
    logic [DataWidth-1:0]     buf_data_q, buf_data_d;
    logic [DataWidth/8-1:0]   buf_strb_q, buf_strb_d;
    logic                     buf_last_q, buf_last_d;
    logic [LenWidth-1:0]      remaining_q, remaining_d;
    logic [OffWidth-1:0]      lane_q, lane_d;
    logic                     pad_q, pad_d;
    logic                     error_q, error_d;

    logic lane_last;
    logic rem_one;
    logic tx_hs;
    logic release_beat;

    assign lane_last   = (lane_q == OffWidth'(NumLanes - 1));
    assign rem_one     = (remaining_q == LenWidth'(1));
    assign busy_o      = (state_q != StIdle);
    assign error_o     = error_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d      = state_q;
        buf_valid_d  = buf_valid_q;
        buf_data_d   = buf_data_q;
        buf_strb_d   = buf_strb_q;
        buf_last_d   = buf_last_q;
        remaining_d  = remaining_q;
        lane_d       = lane_q;
        pad_d        = pad_q;
        error_d      = 1'b0;
        cmd_ready_o  = 1'b0;
        data_ready_o = 1'b0;
        tx_valid_o   = 1'b0;
        tx_data_o    = 16'h0000;
        tx_strb_o    = 2'b00;
        tx_last_o    = 1'b0;
        tx_hs        = 1'b0;
        release_beat = 1'b0;

        case (state_q)
            StIdle: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    if (cmd_len_i != '0) begin
                        state_d     = StRun;
                        remaining_d = cmd_len_i;
                        lane_d      = cmd_offset_i;
                        pad_d       = 1'b0;
                        buf_valid_d = 1'b0;
                    end else begin
                        // A zero-length command has no words to emit but its
                        // input beats still have to be consumed.
                        error_d = 1'b1;
                        state_d = StDrain;
                    end
                end
            end

            StRun: begin
                tx_valid_o = buf_valid_q | pad_q;
                if (buf_valid_q && !pad_q) begin
                    tx_data_o = buf_data_q[{lane_q, 4'b0000} +: 16];
                    tx_strb_o = buf_strb_q[{lane_q, 1'b0} +: 2];
                end
                tx_last_o    = tx_valid_o & rem_one;
                tx_hs        = tx_valid_o & tx_ready_i;
                release_beat = tx_hs & ~pad_q & (lane_last | rem_one);

                // A new beat may replace the one being released, except when
                // the released beat ends the input (padding follows) or the
                // command is finishing (that beat would belong to no command).
                data_ready_o = ~pad_q &
                               (~buf_valid_q | (release_beat & ~buf_last_q & ~rem_one));

                if (tx_hs) begin
                    remaining_d = remaining_q - LenWidth'(1);
                    lane_d      = lane_last ? '0 : lane_q + OffWidth'(1);
                    if (rem_one) begin
                        buf_valid_d = 1'b0;
                        pad_d       = 1'b0;
                        if (pad_q || buf_last_q) begin
                            state_d = StIdle;
                        end else begin
                            // Word count reached before the input's last beat.
                            error_d = 1'b1;
                            state_d = StDrain;
                        end
                    end else if (release_beat) begin
                        buf_valid_d = 1'b0;
                        if (buf_last_q) begin
                            // Input ended early: fill the rest with masked words.
                            pad_d   = 1'b1;
                            error_d = 1'b1;
                        end
                    end
                end

                if (data_valid_i && data_ready_o) begin
                    buf_valid_d = 1'b1;
                    buf_data_d  = data_i;
                    buf_strb_d  = strb_i;
                    buf_last_d  = data_last_i;
                end
            end

            StDrain: begin
                data_ready_o = 1'b1;
                if (data_valid_i && data_last_i) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            buf_strb_q  <= '0;
            buf_last_q  <= 1'b0;
            remaining_q <= '0;
            lane_q      <= '0;
            pad_q       <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            buf_strb_q  <= buf_strb_d;
            buf_last_q  <= buf_last_d;
            remaining_q <= remaining_d;
            lane_q      <= lane_d;
            pad_q       <= pad_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_hyperbus_w_serializer.sv
module tb_hyperbus_w_serializer;

    localparam int DW = 32;
    localparam int NL = DW / 16;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [0:0]    cmd_offset;
    logic [LW-1:0] cmd_len;
    logic          data_valid;
    logic          data_ready;
    logic [DW-1:0] data_in;
    logic [3:0]    strb_in;
    logic          data_last;
    logic          tx_valid;
    logic          tx_ready;
    logic [15:0]   tx_data;
    logic [1:0]    tx_strb;
    logic          tx_last;
    logic          busy;
    logic          err;
    logic [1:0]    dbg_state;

    hyperbus_w_serializer #(.DataWidth(DW), .LenWidth(LW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_offset_i (cmd_offset),
        .cmd_len_i    (cmd_len),
        .data_valid_i (data_valid),
        .data_ready_o (data_ready),
        .data_i       (data_in),
        .strb_i       (strb_in),
        .data_last_i  (data_last),
        .tx_valid_o   (tx_valid),
        .tx_ready_i   (tx_ready),
        .tx_data_o    (tx_data),
        .tx_strb_o    (tx_strb),
        .tx_last_o    (tx_last),
        .busy_o       (busy),
        .error_o      (err),
        .dbg_state_o  (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // word format in both queues: {last, strb[1:0], data[15:0]}
    logic [18:0] exp_q[$];
    logic [18:0] obs_q[$];
    int          exp_err;

    logic [DW-1:0] beat_data[8];
    logic [3:0]    beat_strb[8];

    int n_checks = 0;
    int n_pass   = 0;

    int err_seen, beats_taken, stall_bad, idle_bad, first_hs, last_hs;
    bit timed_out, aborted;

    // Reference model: flatten the beats into a word list (first beat starts
    // at the command offset), take exactly len words, pad with masked zero
    // words if short. An error is expected for len 0, for a short input, or
    // when the final commanded word does not come from the last beat.
    task automatic build_model(input int off, input int len, input int nb);
        logic [17:0] avail[$];
        int          src_beat[$];
        logic [DW-1:0] d;
        logic [3:0]    s;
        exp_q.delete();
        exp_err = 0;
        for (int b = 0; b < nb; b++) begin
            d = beat_data[b];
            s = beat_strb[b];
            for (int l = (b == 0 ? off : 0); l < NL; l++) begin
                avail.push_back({s[l*2 +: 2], d[l*16 +: 16]});
                src_beat.push_back(b);
            end
        end
        if (len == 0) begin
            exp_err = 1;
            return;
        end
        for (int i = 0; i < len; i++) begin
            logic [17:0] w;
            w = (i < avail.size()) ? avail[i] : 18'h0;
            exp_q.push_back({(i == len - 1), w});
        end
        if (avail.size() < len || src_beat[len-1] != nb - 1) exp_err = 1;
    endtask

    // Driver + monitor for one command. Inputs change at the falling edge,
    // outputs are sampled 1 time unit later; handshakes take effect at the
    // following rising edge.
    task automatic run_cmd(input int off, input int len, input int nb,
                           input int ready_mode, input int valid_mode,
                           input int abort_after);
        int          bi;
        bit          cmd_done, prev_stall, finished, rdy;
        logic [18:0] prev_word, cur_word;
        obs_q.delete();
        err_seen = 0; beats_taken = 0; stall_bad = 0; idle_bad = 0;
        first_hs = -1; last_hs = -1; timed_out = 0; aborted = 0;
        bi = 0; cmd_done = 0; prev_stall = 0; finished = 0; prev_word = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            cmd_valid  = !cmd_done;
            cmd_offset = 1'(off);
            cmd_len    = LW'(len);
            data_valid = (bi < nb) && (valid_mode == 0 || $urandom_range(0, 2) != 0);
            data_in    = (bi < nb) ? beat_data[bi] : '0;
            strb_in    = (bi < nb) ? beat_strb[bi] : '0;
            data_last  = (bi == nb - 1);
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tx_ready = rdy;
            #1;
            cur_word = {tx_last, tx_strb, tx_data};
            if (prev_stall && (!tx_valid || cur_word !== prev_word)) stall_bad++;
            if (!tx_valid && (tx_data !== 16'h0 || tx_strb !== 2'b00 || tx_last !== 1'b0))
                idle_bad++;
            if (err === 1'b1) err_seen++;
            if (cmd_done && !busy) begin
                finished = 1;
                break;
            end
            if (cmd_valid && cmd_ready) cmd_done = 1;
            if (data_valid && data_ready) begin
                bi++;
                beats_taken++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_word  = cur_word;
            if (tx_valid && tx_ready) begin
                obs_q.push_back(cur_word);
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                if (abort_after > 0 && obs_q.size() == abort_after) begin
                    aborted = 1;
                    break;
                end
            end
        end
        if (!finished && !aborted) timed_out = 1;
        if (!aborted) begin
            cmd_valid  = 1'b0;
            data_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset cmd_ready got %b exp 1", cmd_ready); else n_pass++;
        n_checks++; if (data_ready !== 1'b0) $display("FAIL reset data_ready got %b exp 0", data_ready); else n_pass++;
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL reset tx_valid got %b exp 0", tx_valid); else n_pass++;
        n_checks++; if (tx_last !== 1'b0) $display("FAIL reset tx_last got %b exp 0", tx_last); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset error got %b exp 0", err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset busy got %b exp 0", busy); else n_pass++;
        n_checks++; if ({tx_strb, tx_data} !== 18'h0) $display("FAIL reset tx_data/strb got %h exp 0", {tx_strb, tx_data}); else n_pass++;
    endtask

    task automatic test_aligned;
        beat_data[0] = 32'hBBBB_AAAA; beat_strb[0] = 4'hF;
        beat_data[1] = 32'hDDDD_CCCC; beat_strb[1] = 4'hF;
        build_model(0, 4, 2);
        run_cmd(0, 4, 2, 0, 0, 0);
        n_checks++; if (exp_q[0] !== {1'b0, 2'b11, 16'hAAAA}) $display("FAIL aligned model word0 got %h exp %h", exp_q[0], {1'b0, 2'b11, 16'hAAAA}); else n_pass++;
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL aligned count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL aligned word%0d got %h exp %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (last_hs - first_hs != 3) $display("FAIL aligned throughput span got %0d exp 3", last_hs - first_hs); else n_pass++;
        n_checks++; if (err_seen != 0) $display("FAIL aligned error pulses got %0d exp 0", err_seen); else n_pass++;
        n_checks++; if (timed_out || dbg_state !== 2'd0) $display("FAIL aligned end idle got state %0d timeout %0d exp 0", dbg_state, timed_out); else n_pass++;
        n_checks++; if (idle_bad != 0) $display("FAIL aligned idle outputs got %0d exp 0", idle_bad); else n_pass++;
    endtask

    task automatic test_unaligned;
        beat_data[0] = 32'h1111_0000; beat_strb[0] = 4'hC;
        beat_data[1] = 32'h3333_2222; beat_strb[1] = 4'h3;
        build_model(1, 3, 2);
        run_cmd(1, 3, 2, 0, 0, 0);
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL unaligned count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL unaligned word%0d got %h exp %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (err_seen != 0 || timed_out) $display("FAIL unaligned errors got %0d timeout %0d exp 0", err_seen, timed_out); else n_pass++;
    endtask

    task automatic test_short_input;
        for (int b = 0; b < 2; b++) begin beat_data[b] = $urandom; beat_strb[b] = 4'($urandom); end
        build_model(0, 5, 2);
        run_cmd(0, 5, 2, 0, 0, 0);
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL short count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL short word%0d got %h exp %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (err_seen != 1) $display("FAIL short error pulses got %0d exp 1", err_seen); else n_pass++;
        n_checks++; if (timed_out) $display("FAIL short timeout got 1 exp 0"); else n_pass++;
    endtask

    task automatic test_long_input;
        for (int b = 0; b < 3; b++) begin beat_data[b] = $urandom; beat_strb[b] = 4'($urandom); end
        build_model(0, 2, 3);
        run_cmd(0, 2, 3, 0, 0, 0);
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL long count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL long word%0d got %h exp %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (err_seen != 1) $display("FAIL long error pulses got %0d exp 1", err_seen); else n_pass++;
        n_checks++; if (beats_taken != 3) $display("FAIL long beats consumed got %0d exp 3", beats_taken); else n_pass++;
        n_checks++; if (timed_out) $display("FAIL long timeout got 1 exp 0"); else n_pass++;
    endtask

    task automatic test_backpressure;
        beat_data[0] = 32'hBBBB_AAAA; beat_strb[0] = 4'hF;
        beat_data[1] = 32'hDDDD_CCCC; beat_strb[1] = 4'hF;
        build_model(0, 4, 2);
        run_cmd(0, 4, 2, 1, 0, 0);
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL backpressure count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL backpressure word%0d got %h exp %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (stall_bad != 0) $display("FAIL backpressure stall stability got %0d exp 0", stall_bad); else n_pass++;
        n_checks++; if (beats_taken != 2 || timed_out) $display("FAIL backpressure beats got %0d timeout %0d exp 2/0", beats_taken, timed_out); else n_pass++;
    endtask

    task automatic test_reset_mid_burst;
        beat_data[0] = 32'hBBBB_AAAA; beat_strb[0] = 4'hF;
        beat_data[1] = 32'hDDDD_CCCC; beat_strb[1] = 4'hF;
        run_cmd(0, 4, 2, 0, 0, 2);
        n_checks++; if (!aborted) $display("FAIL midreset reached word2 got 0 exp 1"); else n_pass++;
        @(negedge clk);
        rst_n = 1'b0; cmd_valid = 1'b0; data_valid = 1'b0; tx_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (tx_valid !== 1'b0) $display("FAIL midreset tx_valid got %b exp 0", tx_valid); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL midreset cmd_ready got %b exp 1", cmd_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL midreset busy got %b exp 0", busy); else n_pass++;
        build_model(0, 4, 2);
        run_cmd(0, 4, 2, 0, 0, 0);
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL midreset rerun count got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL midreset rerun word%0d got %h exp %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (err_seen != 0 || timed_out) $display("FAIL midreset rerun errors got %0d timeout %0d exp 0", err_seen, timed_out); else n_pass++;
    endtask

    task automatic test_random;
        int off, len, nb, rm, vm;
        for (int t = 0; t < 40; t++) begin
            off = $urandom_range(0, NL - 1);
            len = $urandom_range(0, 9);
            nb  = $urandom_range(1, 4);
            rm  = $urandom_range(0, 2);
            vm  = $urandom_range(0, 1);
            for (int b = 0; b < nb; b++) begin beat_data[b] = $urandom; beat_strb[b] = 4'($urandom); end
            build_model(off, len, nb);
            run_cmd(off, len, nb, rm, vm, 0);
            n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL random%0d count got %0d exp %0d", t, obs_q.size(), exp_q.size()); else n_pass++;
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL random%0d word%0d got %h exp %h", t, i, obs_q[i], exp_q[i]); else n_pass++;
            end
            n_checks++; if (err_seen != exp_err) $display("FAIL random%0d error pulses got %0d exp %0d", t, err_seen, exp_err); else n_pass++;
            n_checks++; if (beats_taken != nb) $display("FAIL random%0d beats got %0d exp %0d", t, beats_taken, nb); else n_pass++;
            n_checks++; if (stall_bad != 0 || idle_bad != 0) $display("FAIL random%0d stability got %0d/%0d exp 0/0", t, stall_bad, idle_bad); else n_pass++;
            n_checks++; if (timed_out) $display("FAIL random%0d timeout got 1 exp 0", t); else n_pass++;
        end
    endtask

    // reset, test sequence, report
    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_offset = '0;
        cmd_len    = '0;
        data_valid = 1'b0;
        data_in    = '0;
        strb_in    = '0;
        data_last  = 1'b0;
        tx_ready   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_aligned();
        test_unaligned();
        test_short_input();
        test_long_input();
        test_backpressure();
        test_reset_mid_burst();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
